// File: rtl/fifo_pkg.sv
// Shared defaults and width helper for the single-clock byte FIFO.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // Pointer width for a power-of-2 depth; count is one bit wider.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port RAM: synchronous write, registered read.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is never cleared; only the read register resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write on an address collision returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with registered read data and status flags.
// Define FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = ptr_w(DEPTH)
) (
    input  logic              inp_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inp_d,
    input  logic              inp_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_d,
    output logic              out_valid,
    output logic              full,
    output logic              empty,
`ifdef FIFO_ERR_EN
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Handshake: a write is taken when inp_valid is high and there is room,
    // counting the slot freed by a same-cycle read; a read is taken when
    // out_ready is high and the FIFO is non-empty. Popped data appears on
    // out_d with out_valid high exactly one cycle after the accepting edge;
    // out_valid is a one-cycle pulse per pop, not a held level.
    assign rd_acc = out_ready & ~empty;
    assign wr_acc = inp_valid & (~full | rd_acc);

    always_ff @(posedge inp_clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            out_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_EN
    always_ff @(posedge inp_clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (inp_valid & full & ~out_ready) begin
                overflow <= 1'b1;
            end
            if (out_ready & empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (inp_clk),
        .rst   (reset),
        .we    (wr_acc & ~reset),
        .waddr (wr_ptr),
        .wdata (inp_d),
        .re    (rd_acc & ~reset),
        .raddr (rd_ptr),
        .rdata (out_d)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table, directed corners and a random run against a queue model.
module tb_sync_fifo;

    localparam int DEPTH = 16;

    logic       inp_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] inp_d = '0;
    logic       inp_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_d;
    logic       out_valid;
    logic       full;
    logic       empty;
    logic [4:0] count;
`ifdef FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    sync_fifo dut (
        .inp_clk   (inp_clk),
        .reset     (reset),
        .inp_d     (inp_d),
        .inp_valid (inp_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_valid (out_valid),
        .full      (full),
        .empty     (empty),
`ifdef FIFO_ERR_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .count     (count)
    );

    always #5 inp_clk = ~inp_clk;

    // Reference model: a queue of stored bytes plus the last popped byte.
    logic [7:0] exp_q[$];
    logic [7:0] exp_d = '0;
    logic       exp_v = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("empty", 32'(empty), 32'(exp_q.size() == 0));
        chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("out_d", 32'(out_d), 32'(exp_d));
`ifdef FIFO_ERR_EN
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_unf));
`endif
    endtask

    // Drive one cycle, advance the model by the FIFO rules, check #1 after the edge.
    task automatic step(input logic rst, input logic v, input logic [7:0] d, input logic r);
        logic rd;
        logic wr;
        reset = rst;
        inp_valid = v;
        inp_d = d;
        out_ready = r;
        @(posedge inp_clk);
        if (rst) begin
            exp_q.delete();
            exp_d = '0;
            exp_v = 1'b0;
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            rd = r && (exp_q.size() > 0);
            wr = v && ((exp_q.size() < DEPTH) || rd);
            if (v && exp_q.size() == DEPTH && !r) exp_ovf = 1'b1;
            if (r && exp_q.size() == 0) exp_unf = 1'b1;
            if (rd) begin
                exp_d = exp_q.pop_front();
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            if (wr) exp_q.push_back(d);
        end
        #1;
        check_all();
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        int         ec;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Three writes, three reads, idle, then write+read on empty and a final read.
        vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1};
        vecs[1] = '{1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 2};
        vecs[2] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 2};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};
        vecs[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 0};

        // Reset for two cycles.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_d", 32'(out_d), 32'd0);

        for (int i = 0; i < 9; i++) begin
            step(1'b0, vecs[i].v, vecs[i].d, vecs[i].r);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_d", i), 32'(out_d), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ec));
        end
        chk("vec_end_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, attempt a dropped write, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("drop_count", 32'(count), 32'd16);
`ifdef FIFO_ERR_EN
        chk("drop_overflow", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_order", 32'(out_d), 32'(8'h10 + i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Full with simultaneous write and read for 40 cycles across pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 8'(DEPTH + i), 1'b1);
            chk("hold_count", 32'(count), 32'd16);
            chk("hold_order", 32'(out_d), 32'(8'(i)));
        end

        // Mid-stream reset with five entries stored, then fresh traffic.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_data", 32'(out_d), 32'h3C);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 50));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
